// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP IP-to-MAC cache.
package arp_pkg;

    typedef logic [31:0] ip_addr_t;
    typedef logic [47:0] mac_addr_t;

    localparam logic [31:0] ARP_HASH_POLY = 32'h04C11DB7;
    localparam logic [31:0] ARP_HASH_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        SWEEP  = 2'd0,
        IDLE   = 2'd1,
        LOOKUP = 2'd2,
        RESP   = 2'd3
    } arp_cache_state_e;

endpackage

// File: rtl/lfsr.sv
// Combinational Galois LFSR/CRC step over a DATAW-bit word.
module lfsr #(
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] LFSR_POLY = 32'h04C11DB7,
    parameter bit                REVERSE   = 1'b0,
    parameter int                DATAW     = 8
) (
    input  logic [LFSR_W-1:0] state_in,
    input  logic [DATAW-1:0]  data_in,
    output logic [LFSR_W-1:0] state_out
);

    function automatic logic [LFSR_W-1:0] bit_rev(input logic [LFSR_W-1:0] v);
        logic [LFSR_W-1:0] r;
        for (int i = 0; i < LFSR_W; i++) r[i] = v[LFSR_W-1-i];
        return r;
    endfunction

    // REVERSE shifts right with the mirrored polynomial and consumes data LSB first.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s_in,
                                                    input logic [DATAW-1:0]  d_in);
        logic [LFSR_W-1:0] s;
        logic              fb;
        s = s_in;
        for (int i = 0; i < DATAW; i++) begin
            if (REVERSE) begin
                fb = s[0] ^ d_in[i];
                s  = s >> 1;
                if (fb) s = s ^ bit_rev(LFSR_POLY);
            end else begin
                fb = s[LFSR_W-1] ^ d_in[DATAW-1-i];
                s  = s << 1;
                if (fb) s = s ^ LFSR_POLY;
            end
        end
        return s;
    endfunction

    assign state_out = lfsr_next(state_in, data_in);

endmodule

// File: rtl/arp_cache.sv
// Direct-mapped IP-to-MAC cache indexed by the low bits of the CRC32 of the IP.
//
// state  | meaning
// SWEEP  | invalidating one entry per cycle; no requests accepted
// IDLE   | ready for a lookup; writes accepted
// LOOKUP | reading valid/tag/MAC at the registered index
// RESP   | holding the response until query_resp_ready
module arp_cache
    import arp_pkg::*;
#(
    parameter int CACHE_ADDRW = 9
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      query_req_valid,
    output logic      query_req_ready,
    input  ip_addr_t  query_req_ip,
    output logic      query_resp_valid,
    input  logic      query_resp_ready,
    output logic      query_resp_error,
    output mac_addr_t query_resp_mac,
    input  logic      write_req_valid,
    output logic      write_req_ready,
    input  ip_addr_t  write_req_ip,
    input  mac_addr_t write_req_mac,
    input  logic      clear_cache
);

    localparam int DEPTH = 1 << CACHE_ADDRW;
    localparam logic [CACHE_ADDRW-1:0] CNT_LAST = {CACHE_ADDRW{1'b1}};

    arp_cache_state_e       state_q, state_d;
    logic [CACHE_ADDRW-1:0] cnt_q, cnt_d;
    logic [CACHE_ADDRW-1:0] idx_q, idx_d;
    ip_addr_t               ip_q, ip_d;
    logic                   clr_pend_q, clr_pend_d;
    logic                   err_q, err_d;
    mac_addr_t              mac_q, mac_d;

    logic [DEPTH-1:0] valid_q;
    ip_addr_t         tag_mem [DEPTH];
    mac_addr_t        mac_mem [DEPTH];

    logic [31:0]            q_hash, w_hash;
    logic [CACHE_ADDRW-1:0] q_idx, w_idx;
    logic                   unused_hash_bits;
    logic                   q_acc, w_acc, w_en;
    logic                   lk_valid, lk_hit;
    ip_addr_t               lk_tag;
    mac_addr_t              lk_mac;

    lfsr #(.LFSR_W(32), .LFSR_POLY(ARP_HASH_POLY), .REVERSE(1'b1), .DATAW(32)) u_query_hash (
        .state_in (ARP_HASH_INIT),
        .data_in  (query_req_ip),
        .state_out(q_hash)
    );

    lfsr #(.LFSR_W(32), .LFSR_POLY(ARP_HASH_POLY), .REVERSE(1'b1), .DATAW(32)) u_write_hash (
        .state_in (ARP_HASH_INIT),
        .data_in  (write_req_ip),
        .state_out(w_hash)
    );

    assign q_idx            = ~q_hash[CACHE_ADDRW-1:0];
    assign w_idx            = ~w_hash[CACHE_ADDRW-1:0];
    assign unused_hash_bits = ^{q_hash[31:CACHE_ADDRW], w_hash[31:CACHE_ADDRW]};

    // A clear in IDLE wins over a simultaneous lookup, so the lookup is not accepted.
    assign query_req_ready = (state_q == IDLE) && !clear_cache;
    assign write_req_ready = (state_q != SWEEP);
    assign q_acc           = query_req_valid && query_req_ready;
    assign w_acc           = write_req_valid && write_req_ready;
    assign w_en            = w_acc && !clear_cache;

    // A write landing on the index being looked up is forwarded to the read.
    always_comb begin
        lk_valid = valid_q[idx_q];
        lk_tag   = tag_mem[idx_q];
        lk_mac   = mac_mem[idx_q];
        if (w_en && (w_idx == idx_q)) begin
            lk_valid = 1'b1;
            lk_tag   = write_req_ip;
            lk_mac   = write_req_mac;
        end
        lk_hit = lk_valid && (lk_tag == ip_q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ip_d       = ip_q;
        clr_pend_d = clr_pend_q;
        err_d      = err_q;
        mac_d      = mac_q;
        case (state_q)
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (clear_cache) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear_cache) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end else if (q_acc) begin
                    ip_d    = query_req_ip;
                    idx_d   = q_idx;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                err_d   = !lk_hit;
                mac_d   = lk_hit ? lk_mac : '0;
                state_d = RESP;
                if (clear_cache) clr_pend_d = 1'b1;
            end
            RESP: begin
                if (clear_cache) clr_pend_d = 1'b1;
                if (query_resp_ready) begin
                    if (clr_pend_q || clear_cache) begin
                        state_d    = SWEEP;
                        cnt_d      = '0;
                        clr_pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SWEEP;
            cnt_q      <= '0;
            idx_q      <= '0;
            ip_q       <= '0;
            clr_pend_q <= 1'b0;
            err_q      <= 1'b0;
            mac_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            ip_q       <= ip_d;
            clr_pend_q <= clr_pend_d;
            err_q      <= err_d;
            mac_q      <= mac_d;
        end
    end

    // Valid bits are only ever cleared by the sweep, which always follows reset.
    always_ff @(posedge clk) begin
        if (state_q == SWEEP) begin
            valid_q[cnt_q] <= 1'b0;
        end else if (w_en) begin
            valid_q[w_idx] <= 1'b1;
        end
        if (w_en) begin
            tag_mem[w_idx] <= write_req_ip;
            mac_mem[w_idx] <= write_req_mac;
        end
    end

    assign query_resp_valid = (state_q == RESP);
    assign query_resp_error = query_resp_valid && err_q;
    assign query_resp_mac   = query_resp_valid ? mac_q : '0;

endmodule

// File: tb/tb_arp_cache.sv
// Directed bench for arp_cache: vector table plus sweep, clear and reset sequences.
module tb_arp_cache;
    import arp_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      query_req_valid, query_req_ready;
    ip_addr_t  query_req_ip;
    logic      query_resp_valid, query_resp_ready, query_resp_error;
    mac_addr_t query_resp_mac;
    logic      write_req_valid, write_req_ready;
    ip_addr_t  write_req_ip;
    mac_addr_t write_req_mac;
    logic      clear_cache;

    int errors = 0;
    int checks = 0;

    arp_cache #(.CACHE_ADDRW(9)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .query_req_valid  (query_req_valid),
        .query_req_ready  (query_req_ready),
        .query_req_ip     (query_req_ip),
        .query_resp_valid (query_resp_valid),
        .query_resp_ready (query_resp_ready),
        .query_resp_error (query_resp_error),
        .query_resp_mac   (query_resp_mac),
        .write_req_valid  (write_req_valid),
        .write_req_ready  (write_req_ready),
        .write_req_ip     (write_req_ip),
        .write_req_mac    (write_req_mac),
        .clear_cache      (clear_cache)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit        is_wr;
        ip_addr_t  ip;
        mac_addr_t mac;
        logic      exp_err;
        mac_addr_t exp_mac;
        string     name;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Bytewise reflected CRC32 of the IP word, bytes taken LSB first.
    function automatic logic [8:0] model_idx(input logic [31:0] ip);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int b = 0; b < 4; b++) begin
            c = c ^ {24'h0, ip[8*b +: 8]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c[8:0];
    endfunction

    task automatic set_vec(input int i, input bit w, input ip_addr_t ip, input mac_addr_t mac,
                           input logic e, input mac_addr_t em, input string name);
        vecs[i].is_wr   = w;
        vecs[i].ip      = ip;
        vecs[i].mac     = mac;
        vecs[i].exp_err = e;
        vecs[i].exp_mac = em;
        vecs[i].name    = name;
    endtask

    task automatic sweep_count(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (query_req_ready !== 1'b1 && n < 2000);
        chk({name, "_cycles"}, n, 512);
        chk({name, "_wr_ready"}, write_req_ready, 1'b1);
    endtask

    task automatic do_write(input ip_addr_t ip, input mac_addr_t mac);
        int n;
        n = 0;
        write_req_valid = 1'b1;
        write_req_ip    = ip;
        write_req_mac   = mac;
        while (write_req_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) chk("write_ready_timeout", n, 0);
        @(posedge clk); #1;
        write_req_valid = 1'b0;
    endtask

    task automatic do_query(input string name, input ip_addr_t ip, input logic exp_err,
                            input mac_addr_t exp_mac);
        int n;
        n = 0;
        query_req_valid = 1'b1;
        query_req_ip    = ip;
        while (query_req_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) chk({name, "_req_timeout"}, n, 0);
        @(posedge clk); #1;
        query_req_valid = 1'b0;
        chk({name, "_early_valid"}, query_resp_valid, 1'b0);
        @(posedge clk); #1;
        chk({name, "_valid"}, query_resp_valid, 1'b1);
        chk({name, "_error"}, query_resp_error, exp_err);
        chk({name, "_mac"}, query_resp_mac, exp_mac);
        query_resp_ready = 1'b1;
        @(posedge clk); #1;
        query_resp_ready = 1'b0;
        chk({name, "_drained"}, query_resp_valid, 1'b0);
    endtask

    initial begin
        ip_addr_t ip_a, ip_b;

        rst_n            = 1'b0;
        query_req_valid  = 1'b0;
        query_req_ip     = '0;
        query_resp_ready = 1'b0;
        write_req_valid  = 1'b0;
        write_req_ip     = '0;
        write_req_mac    = '0;
        clear_cache      = 1'b0;

        #2;
        chk("rst_q_ready", query_req_ready, 1'b0);
        chk("rst_w_ready", write_req_ready, 1'b0);
        chk("rst_resp_valid", query_resp_valid, 1'b0);
        chk("rst_resp_error", query_resp_error, 1'b0);
        chk("rst_resp_mac", query_resp_mac, 48'h0);

        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_count("reset_sweep");

        ip_a = 32'hAC100001;
        ip_b = ip_a + 1;
        for (int i = 0; i < 100000 && model_idx(ip_b) != model_idx(ip_a); i++) ip_b++;

        set_vec(0, 1'b0, 32'hC0A8010A, 48'h0,          1'b1, 48'h0,          "q_cold_miss");
        set_vec(1, 1'b1, 32'hC0A8010A, 48'h020000AABBCC, 1'b0, 48'h0,        "w_first");
        set_vec(2, 1'b0, 32'hC0A8010A, 48'h0,          1'b0, 48'h020000AABBCC, "q_first_hit");
        set_vec(3, 1'b1, ip_a,         48'hA1A1A1A1A1A1, 1'b0, 48'h0,        "w_coll_a");
        set_vec(4, 1'b1, ip_b,         48'hB2B2B2B2B2B2, 1'b0, 48'h0,        "w_coll_b");
        set_vec(5, 1'b0, ip_a,         48'h0,          1'b1, 48'h0,          "q_evicted_a");
        set_vec(6, 1'b0, ip_b,         48'h0,          1'b0, 48'hB2B2B2B2B2B2, "q_coll_b");
        set_vec(7, 1'b1, 32'hC0A8010A, 48'h020000AABBDD, 1'b0, 48'h0,        "w_update");
        set_vec(8, 1'b0, 32'hC0A8010A, 48'h0,          1'b0, 48'h020000AABBDD, "q_updated");
        set_vec(9, 1'b0, 32'h08080808, 48'h0,          1'b1, 48'h0,          "q_unknown");

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].ip, vecs[i].mac);
            else do_query(vecs[i].name, vecs[i].ip, vecs[i].exp_err, vecs[i].exp_mac);
        end

        // Write and query accepted on the same edge.
        query_req_valid = 1'b1;
        query_req_ip    = 32'h0A000001;
        write_req_valid = 1'b1;
        write_req_ip    = 32'h0A000001;
        write_req_mac   = 48'h112233445566;
        chk("same_q_ready", query_req_ready, 1'b1);
        chk("same_w_ready", write_req_ready, 1'b1);
        @(posedge clk); #1;
        query_req_valid = 1'b0;
        write_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("same_valid", query_resp_valid, 1'b1);
        chk("same_error", query_resp_error, 1'b0);
        chk("same_mac", query_resp_mac, 48'h112233445566);
        query_resp_ready = 1'b1;
        @(posedge clk); #1;
        query_resp_ready = 1'b0;

        // Write to the looked-up index while in LOOKUP.
        query_req_valid = 1'b1;
        query_req_ip    = 32'h0A00004D;
        @(posedge clk); #1;
        query_req_valid = 1'b0;
        write_req_valid = 1'b1;
        write_req_ip    = 32'h0A00004D;
        write_req_mac   = 48'h0A0B0C0D0E0F;
        @(posedge clk); #1;
        write_req_valid = 1'b0;
        chk("lookup_fwd_valid", query_resp_valid, 1'b1);
        chk("lookup_fwd_error", query_resp_error, 1'b0);
        chk("lookup_fwd_mac", query_resp_mac, 48'h0A0B0C0D0E0F);
        query_resp_ready = 1'b1;
        @(posedge clk); #1;
        query_resp_ready = 1'b0;

        // Clear while a response is held.
        do_write(32'hC0A80214, 48'hCAFE00000001);
        query_req_valid = 1'b1;
        query_req_ip    = 32'hC0A80214;
        @(posedge clk); #1;
        query_req_valid = 1'b0;
        @(posedge clk); #1;
        clear_cache = 1'b1;
        @(posedge clk); #1;
        clear_cache = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("held_valid", query_resp_valid, 1'b1);
            chk("held_error", query_resp_error, 1'b0);
            chk("held_mac", query_resp_mac, 48'hCAFE00000001);
            chk("held_q_ready", query_req_ready, 1'b0);
            @(posedge clk); #1;
        end
        query_resp_ready = 1'b1;
        @(posedge clk); #1;
        query_resp_ready = 1'b0;
        chk("clear_drained", query_resp_valid, 1'b0);
        chk("clear_w_ready", write_req_ready, 1'b0);
        sweep_count("clear_sweep");
        do_query("requery_after_clear", 32'hC0A80214, 1'b1, 48'h0);

        // Reset while in LOOKUP.
        query_req_valid = 1'b1;
        query_req_ip    = 32'hC0A8010A;
        @(posedge clk); #1;
        query_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_lookup_valid", query_resp_valid, 1'b0);
        chk("rst_lookup_q_ready", query_req_ready, 1'b0);
        chk("rst_lookup_w_ready", write_req_ready, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_lookup_valid_late", query_resp_valid, 1'b0);
        rst_n = 1'b1;
        sweep_count("rst_lookup_sweep");
        chk("rst_lookup_lost", query_resp_valid, 1'b0);

        // Reset partway through a sweep.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("mid_sweep_q_ready", query_req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_sweep_w_ready", write_req_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_count("rst_sweep200_sweep");
        do_query("q_after_resets", 32'hC0A8010A, 1'b1, 48'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
